uart_tx_queue: RTL and testbench

- Transmit-side byte queue that sits directly upstream of the UART sender.
- Accepts bytes from the peripheral bus bridge, buffers them in a FIFO, and launches one sender frame at a time.
- Launch uses the sender's tx_en / tx_status handshake and holds tx_data stable for the whole frame.
- Runs entirely in the baud-clock (16x oversample) domain; the bridge presents writes synchronous to baudclk.

---
 rtl/uart_tx_queue.sv | 113 +++++++++++
 tb/tb_uart_tx_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO feeding the UART sender through a tx_en/tx_status launch handshake
`timescale 1ns/1ps
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  baudclk,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  input  logic                  tx_status
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic                  accept;
  logic                  drop;
  logic                  pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;

  // Full is judged on the registered count, so a pop on the same edge cannot rescue a write.
  assign accept = wr_en && !full;
  assign drop   = wr_en && full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_status) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_status) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_status) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = (state_d == LAUNCH);
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      tx_data_d = mem[rd_ptr_q];
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge baudclk) begin
    if (accept) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed-vector bench for uart_tx_queue with a behavioural UART sender
`timescale 1ns/1ps
module tb_uart_tx_queue;

  localparam int BIT_CYC = 16;

  logic       baudclk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       clr_overflow;
  logic       full, empty, overflow, busy, tx_en, tx_status;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       hold_busy;

  int n_vec  = 0;
  int n_miss = 0;

  uart_tx_queue #(.DEPTH_LOG2(4)) dut (
    .baudclk      (baudclk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_status    (tx_status)
  );

  always #5 baudclk = ~baudclk;

  // Sender model: start bit, 8 data bits LSB first, stop bit; BIT_CYC clocks per bit.
  logic       sender_idle;
  logic       line;
  logic [9:0] sh;
  logic [7:0] cur;
  logic [3:0] bitn;
  logic [4:0] cyc;
  logic       bit_mem [2048];
  int         bit_wr = 0;
  logic [7:0] rx_mem [256];
  int         rx_wr = 0;
  int         changed_cnt = 0;
  int         pulses = 0;
  int         consec = 0;
  logic       tx_en_prev = 1'b0;

  assign tx_status = sender_idle & ~hold_busy;

  always @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      sender_idle <= 1'b1;
      line        <= 1'b1;
      cyc         <= '0;
      bitn        <= '0;
    end else if (sender_idle) begin
      if (tx_en) begin
        sender_idle         <= 1'b0;
        sh                  <= {1'b1, tx_data, 1'b0};
        cur                 <= tx_data;
        line                <= 1'b0;
        bit_mem[bit_wr % 2048] <= 1'b0;
        bit_wr              <= bit_wr + 1;
        cyc                 <= '0;
        bitn                <= '0;
      end
    end else begin
      if (tx_data != cur) changed_cnt <= changed_cnt + 1;
      if (cyc == 5'(BIT_CYC - 1)) begin
        cyc <= '0;
        if (bitn == 4'd9) begin
          sender_idle           <= 1'b1;
          line                  <= 1'b1;
          rx_mem[rx_wr % 256]   <= cur;
          rx_wr                 <= rx_wr + 1;
        end else begin
          bitn                   <= bitn + 4'd1;
          line                   <= sh[bitn + 4'd1];
          bit_mem[bit_wr % 2048] <= sh[bitn + 4'd1];
          bit_wr                 <= bit_wr + 1;
        end
      end else begin
        cyc <= cyc + 5'd1;
      end
    end
  end

  always @(posedge baudclk) begin
    if (tx_en) pulses <= pulses + 1;
    if (tx_en && tx_en_prev) consec <= consec + 1;
    tx_en_prev <= tx_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge baudclk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (!(busy == 1'b0 && tx_status == 1'b1) && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_txen(input string tag, input int maxc);
    int n = 0;
    while (tx_en !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_status(input string tag, input logic v, input int maxc);
    int n = 0;
    while (tx_status !== v && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 32'(n < maxc), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0, r0, b0;
    logic [9:0] v;
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0; hold_busy = 1'b0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txen", 32'(tx_en), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'h00);
    repeat (2) @(posedge baudclk);
    #1 reset = 1'b1;
    tick();

    // single byte A5, latency and serial waveform
    p0 = pulses; b0 = bit_wr;
    write_byte(8'hA5);
    check("t1_cnt_wr", 32'(count), 32'd1);
    check("t1_txen_early", 32'(tx_en), 32'd0);
    tick();
    check("t1_txen", 32'(tx_en), 32'd1);
    check("t1_txdata", 32'(tx_data), 32'hA5);
    check("t1_cnt_pop", 32'(count), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_txen_off", 32'(tx_en), 32'd0);
    wait_idle("t1_idle", 400);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    check("t1_nbits", 32'(bit_wr - b0), 32'd10);
    v = '0;
    for (int i = 0; i < 10; i++) v = {v[8:0], bit_mem[(b0 + i) % 2048]};
    check("t1_line", 32'(v), 32'h14B);

    // burst of 16 into a held-busy sender, then drain in order
    p0 = pulses; r0 = rx_wr;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_count", 32'(count), 32'd16);
    hold_busy = 1'b0;
    wait_idle("t2_idle", 4000);
    check("t2_pulses", 32'(pulses - p0), 32'd16);
    check("t2_nrx", 32'(rx_wr - r0), 32'd16);
    for (int i = 0; i < 16; i++) check("t2_byte", 32'(rx_mem[(r0 + i) % 256]), 32'(i));
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);

    // overflow: 17th write dropped, set beats clear, clear alone
    r0 = rx_wr;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i));
    check("t3_ovf_pre", 32'(overflow), 32'd0);
    write_byte(8'h50);
    check("t3_ovf_set", 32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd16);
    clr_overflow = 1'b1;
    write_byte(8'h51);
    check("t3_set_wins", 32'(overflow), 32'd1);
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    hold_busy = 1'b0;
    wait_idle("t3_idle", 4000);
    check("t3_nrx", 32'(rx_wr - r0), 32'd16);
    for (int i = 0; i < 16; i++) check("t3_byte", 32'(rx_mem[(r0 + i) % 256]), 32'h40 + 32'(i));

    // tx_data held through an in-flight frame while the next byte queues
    r0 = rx_wr;
    write_byte(8'h11);
    wait_txen("t4_txen1_to", 10);
    repeat (3) tick();
    check("t4_inflight", 32'(tx_status), 32'd0);
    write_byte(8'h3C);
    check("t4_hold1", 32'(tx_data), 32'h11);
    wait_status("t4_done_to", 1'b1, 400);
    check("t4_hold2", 32'(tx_data), 32'h11);
    wait_txen("t4_txen2_to", 10);
    check("t4_next", 32'(tx_data), 32'h3C);
    wait_idle("t4_idle", 400);
    check("t4_rx0", 32'(rx_mem[r0 % 256]), 32'h11);
    check("t4_rx1", 32'(rx_mem[(r0 + 1) % 256]), 32'h3C);

    // write coincides with pop from a 1-entry queue
    r0 = rx_wr;
    hold_busy = 1'b1;
    write_byte(8'h77);
    check("t6_cnt1", 32'(count), 32'd1);
    wr_data = 8'h88; wr_en = 1'b1; hold_busy = 1'b0;
    tick();
    wr_en = 1'b0;
    check("t6_cnt_same", 32'(count), 32'd1);
    check("t6_txdata", 32'(tx_data), 32'h77);
    wait_idle("t6_idle", 800);
    check("t6_rx0", 32'(rx_mem[r0 % 256]), 32'h77);
    check("t6_rx1", 32'(rx_mem[(r0 + 1) % 256]), 32'h88);

    // async reset during WAIT_DONE with 3 bytes queued
    write_byte(8'h55);
    wait_txen("t5_txen_to", 10);
    repeat (3) tick();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    check("t5_cnt3", 32'(count), 32'd3);
    check("t5_inflight", 32'(tx_status), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("t5_count", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_full", 32'(full), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_txen", 32'(tx_en), 32'd0);
    check("t5_txdata", 32'(tx_data), 32'h00);
    check("t5_ovf", 32'(overflow), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    p0 = pulses;
    repeat (400) tick();
    check("t5_no_launch", 32'(pulses - p0), 32'd0);
    check("t5_empty_end", 32'(empty), 32'd1);

    check("txen_consec", 32'(consec), 32'd0);
    check("txdata_changed", 32'(changed_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
